hazard_ctrl: RTL and testbench

- Pipeline hazard controller; produces the `stall` and `nop` controls consumed by the decode-to-execute pipeline register.
- Also produces fetch-side hold/flush and a global freeze.
- Keeps its own shadow scoreboard of the instructions in EX and MEM, updated in lockstep with the pipe registers.
- Detects RAW (load-use) hazards, taken-branch redirects, data-memory busy and halt. Sits beside the decode stage.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 97 +++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bus: instruction fields and pipe status in, pipeline
// register controls and stall statistics out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             idValid;
    logic [2:0]       idRs;
    logic             idRsUsed;
    logic [2:0]       idRt;
    logic             idRtUsed;
    logic [2:0]       idWriteRegister;
    logic             idRegisterWrite;
    logic             idMemoryRead;
    logic             idHalt;
    logic             exRedirect;
    logic             memBusy;
    logic             stall;
    logic             nop;
    logic             flush;
    logic             freeze;
    logic             halted;
    logic [CNT_W-1:0] stallCount;

    modport master (
        output idValid, idRs, idRsUsed, idRt, idRtUsed, idWriteRegister,
               idRegisterWrite, idMemoryRead, idHalt, exRedirect, memBusy,
        input  stall, nop, flush, freeze, halted, stallCount
    );

    modport slave (
        input  idValid, idRs, idRsUsed, idRt, idRtUsed, idWriteRegister,
               idRegisterWrite, idMemoryRead, idHalt, exRedirect, memBusy,
        output stall, nop, flush, freeze, halted, stallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM in a shadow scoreboard and drives
// stall/bubble/flush/freeze for the decode-to-execute boundary.
module hazard_ctrl #(
    parameter bit          FWD   = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic       regWrite;
        logic       memRead;
    } sbEntry_t;

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    state_t           state;
    sbEntry_t         exEnt;
    sbEntry_t         memEnt;
    sbEntry_t         idEnt;
    logic             halted;
    logic [CNT_W-1:0] stallCnt;

    logic matchEx;
    logic matchMem;
    logic hz;
    logic freezeC;
    logic flushC;
    logic stallC;
    logic nopC;

    // Hazard detection and priority-ordered pipe controls.
    always_comb begin
        matchEx  = (bus.idRsUsed && (bus.idRs == exEnt.rd)) ||
                   (bus.idRtUsed && (bus.idRt == exEnt.rd));
        matchMem = (bus.idRsUsed && (bus.idRs == memEnt.rd)) ||
                   (bus.idRtUsed && (bus.idRt == memEnt.rd));
        if (FWD) begin
            // With forwarding only a load still in EX cannot be bypassed.
            hz = bus.idValid & exEnt.valid & exEnt.regWrite & exEnt.memRead & matchEx;
        end else begin
            hz = bus.idValid & ((exEnt.valid & exEnt.regWrite & matchEx) |
                                (memEnt.valid & memEnt.regWrite & matchMem));
        end
        freezeC = bus.memBusy | ((state == MEMWAIT) & bus.memBusy);
        flushC  = bus.exRedirect & ~freezeC;
        stallC  = ~freezeC & ~flushC & (hz | halted);
        nopC    = ~freezeC & (flushC | hz | halted);
        idEnt   = '{valid: 1'b1, rd: bus.idWriteRegister,
                    regWrite: bus.idRegisterWrite, memRead: bus.idMemoryRead};
    end

    // Scoreboard, halt latch, memory-wait FSM and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            exEnt    <= '0;
            memEnt   <= '0;
            halted   <= 1'b0;
            stallCnt <= '0;
        end else begin
            case (state)
                RUN:     if (bus.memBusy)  state <= MEMWAIT;
                MEMWAIT: if (!bus.memBusy) state <= RUN;
                default: state <= RUN;
            endcase

            if ((stallC || freezeC) && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end

            if (!freezeC) begin
                memEnt <= exEnt;
                if (nopC || !bus.idValid) begin
                    exEnt <= '0;
                end else begin
                    exEnt <= idEnt;
                    if (bus.idHalt) halted <= 1'b1;
                end
            end
        end
    end

    assign bus.stall      = stallC;
    assign bus.nop        = nopC;
    assign bus.flush      = flushC;
    assign bus.freeze     = freezeC;
    assign bus.halted     = halted;
    assign bus.stallCount = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (FWD=1, FWD=0, narrow counter)
// share stimulus; a queue of expected outputs is checked at each falling edge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [2:0] rs;
        logic       rsUsed;
        logic [2:0] rt;
        logic       rtUsed;
        logic [2:0] wr;
        logic       regW;
        logic       memR;
        logic       halt;
        logic       redir;
        logic       busy;
    } stim_t;

    typedef struct {
        string       tag;
        int          dut;
        logic [20:0] val;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    stim_t cur = '0;
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) ifA ();
    hazard_ctrl_if #(.CNT_W(16)) ifB ();
    hazard_ctrl_if #(.CNT_W(4))  ifC ();

    hazard_ctrl #(.FWD(1'b1), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    hazard_ctrl #(.FWD(1'b0), .CNT_W(16)) dutB (.clk(clk), .rst(rst), .bus(ifB));
    hazard_ctrl #(.FWD(1'b1), .CNT_W(4))  dutC (.clk(clk), .rst(rst), .bus(ifC));

    assign ifA.idValid = cur.valid;   assign ifB.idValid = cur.valid;   assign ifC.idValid = cur.valid;
    assign ifA.idRs = cur.rs;         assign ifB.idRs = cur.rs;         assign ifC.idRs = cur.rs;
    assign ifA.idRsUsed = cur.rsUsed; assign ifB.idRsUsed = cur.rsUsed; assign ifC.idRsUsed = cur.rsUsed;
    assign ifA.idRt = cur.rt;         assign ifB.idRt = cur.rt;         assign ifC.idRt = cur.rt;
    assign ifA.idRtUsed = cur.rtUsed; assign ifB.idRtUsed = cur.rtUsed; assign ifC.idRtUsed = cur.rtUsed;
    assign ifA.idWriteRegister = cur.wr;   assign ifB.idWriteRegister = cur.wr;   assign ifC.idWriteRegister = cur.wr;
    assign ifA.idRegisterWrite = cur.regW; assign ifB.idRegisterWrite = cur.regW; assign ifC.idRegisterWrite = cur.regW;
    assign ifA.idMemoryRead = cur.memR;    assign ifB.idMemoryRead = cur.memR;    assign ifC.idMemoryRead = cur.memR;
    assign ifA.idHalt = cur.halt;          assign ifB.idHalt = cur.halt;          assign ifC.idHalt = cur.halt;
    assign ifA.exRedirect = cur.redir;     assign ifB.exRedirect = cur.redir;     assign ifC.exRedirect = cur.redir;
    assign ifA.memBusy = cur.busy;         assign ifB.memBusy = cur.busy;         assign ifC.memBusy = cur.busy;

    // Observed vector per instance: {stall, nop, flush, freeze, halted, count[15:0]}.
    logic [20:0] obs [3];
    assign obs[0] = {ifA.stall, ifA.nop, ifA.flush, ifA.freeze, ifA.halted, ifA.stallCount};
    assign obs[1] = {ifB.stall, ifB.nop, ifB.flush, ifB.freeze, ifB.halted, ifB.stallCount};
    assign obs[2] = {ifC.stall, ifC.nop, ifC.flush, ifC.freeze, ifC.halted, 12'd0, ifC.stallCount};

    function automatic stim_t mk(input logic v, input logic [2:0] rs, input logic rsu,
                                 input logic [2:0] rt, input logic rtu, input logic [2:0] wr,
                                 input logic rw, input logic mr, input logic h);
        stim_t s;
        s = '0;
        s.valid = v;  s.rs = rs;  s.rsUsed = rsu; s.rt = rt; s.rtUsed = rtu;
        s.wr = wr;    s.regW = rw; s.memR = mr;   s.halt = h;
        return s;
    endfunction

    task automatic push(input string tag, input int dut, input logic [4:0] flags, input int cnt);
        exp_t e;
        e.tag = tag;
        e.dut = dut;
        e.val = {flags, 16'(cnt)};
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (obs[e.dut] === e.val)
            else begin
                errors++;
                $error("FAIL %s dut%0d observed %h expected %h", e.tag, e.dut, obs[e.dut], e.val);
            end
        end
    endtask

    // One clock: drive stimulus after the rising edge, check at the falling edge.
    task automatic step(input stim_t st, input string tag, input int dut,
                        input logic [4:0] flags, input int cnt);
        @(posedge clk);
        #1;
        cur = st;
        push(tag, dut, flags, cnt);
        @(negedge clk);
        chk();
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = '0;
        for (int d = 0; d < 3; d++) push("reset", d, 5'b00000, 0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    stim_t idle, ld3, addRs3, addRs3Redir, addRs3Busy, add2, rdRt2, rdUnused, hlt, hltRedir, busy;

    initial begin
        idle        = '0;
        ld3         = mk(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        addRs3      = mk(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        addRs3Redir = addRs3;
        addRs3Redir.redir = 1'b1;
        addRs3Busy  = addRs3;
        addRs3Busy.busy = 1'b1;
        add2        = mk(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        rdRt2       = mk(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        rdUnused    = mk(1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        hlt         = mk(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        hltRedir    = hlt;
        hltRedir.redir = 1'b1;
        busy        = '0;
        busy.busy   = 1'b1;

        // Power-on reset with idle inputs.
        doReset();

        // Load-use with forwarding: one stall cycle.
        step(ld3,    "lu_ld",      0, 5'b00000, 0);
        step(addRs3, "lu_stall",   0, 5'b11000, 0);
        step(addRs3, "lu_release", 0, 5'b00000, 1);
        step(idle,   "lu_after",   0, 5'b00000, 1);

        // No forwarding: ALU RAW stalls two cycles; an unused source does not.
        doReset();
        step(add2,     "raw_add",     1, 5'b00000, 0);
        step(rdRt2,    "raw_stall1",  1, 5'b11000, 0);
        step(rdRt2,    "raw_stall2",  1, 5'b11000, 1);
        step(rdRt2,    "raw_release", 1, 5'b00000, 2);
        step(add2,     "raw_add2",    1, 5'b00000, 2);
        step(rdUnused, "raw_unused",  1, 5'b00000, 2);

        // Redirect coinciding with load-use: flush wins.
        doReset();
        step(ld3,         "rd_ld",    0, 5'b00000, 0);
        step(addRs3Redir, "rd_flush", 0, 5'b01100, 0);
        step(addRs3,      "rd_after", 0, 5'b00000, 0);

        // Memory busy on top of a load-use stall.
        doReset();
        step(ld3,        "mb_ld",      0, 5'b00000, 0);
        step(addRs3Busy, "mb_freeze1", 0, 5'b00010, 0);
        step(addRs3Busy, "mb_freeze2", 0, 5'b00010, 1);
        step(addRs3Busy, "mb_freeze3", 0, 5'b00010, 2);
        step(addRs3,     "mb_stall",   0, 5'b11000, 3);
        step(addRs3,     "mb_after",   0, 5'b00000, 4);

        // HALT, then asynchronous reset mid-cycle.
        doReset();
        step(hlt,    "halt_dec",   0, 5'b00000, 0);
        step(idle,   "halt_hold1", 0, 5'b11001, 0);
        step(addRs3, "halt_hold2", 0, 5'b11001, 1);
        #2;
        rst = 1'b0;
        cur = idle;
        push("halt_async_rst", 0, 5'b00000, 0);
        #1;
        chk();
        doReset();

        // HALT squashed by a same-cycle redirect.
        step(hltRedir, "halt_redir",  0, 5'b01100, 0);
        step(idle,     "halt_squash", 0, 5'b00000, 0);

        // Saturation of a 4-bit counter under a long freeze.
        doReset();
        for (int i = 0; i < 20; i++) begin
            step(busy, "sat_freeze", 2, 5'b00010, (i < 15) ? i : 15);
        end
        step(idle, "sat_release", 2, 5'b00000, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
